// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared state type, word field offsets and channel-walk helpers
package adc_scan_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_RSP, STORE} state_t;
  localparam int ADDR_LSB = 16;
  localparam int TAG_MSB = 7;
  localparam int TAG_LSB = 3;
  localparam int CH_MSB = 2;
  localparam int SAMPLE_W = 10;
  localparam int TAG_W = 5;
  function automatic logic [2:0] first_ch(input logic [7:0] mask);
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) if (mask[i]) first_ch = 3'(i);
  endfunction
  // Nearest set bit above ch, wrapping 7->0; stays on ch if it is the only one.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] ch);
    next_ch = ch;
    for (int i = 7; i >= 1; i--) if (mask[3'(ch + 3'(i))]) next_ch = 3'(ch + 3'(i));
  endfunction
endpackage

// File: rtl/adc_avg_bank.sv
// adc_avg_bank: per-channel box-car accumulators, result registers and read port
module adc_avg_bank
  import adc_scan_pkg::*;
#(
  parameter int AVG_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [2:0]          wr_ch,
  input  logic [SAMPLE_W-1:0] wr_sample,
  input  logic [2:0]          rd_ch,
  output logic [SAMPLE_W-1:0] rd_value,
  output logic                upd_stb,
  output logic [2:0]          upd_ch
);
  localparam int ACC_W = SAMPLE_W + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  logic [ACC_W-1:0] acc [8];
  logic [CNT_W-1:0] cnt [8];
  logic [SAMPLE_W-1:0] result [8];
  logic [ACC_W-1:0] sum, avg;
  logic full;
  assign sum = acc[wr_ch] + ACC_W'(wr_sample);
  assign avg = sum >> AVG_SHIFT;
  assign full = cnt[wr_ch] == CNT_W'((1 << AVG_SHIFT) - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        result[i] <= '0;
      end
      rd_value <= '0;
      upd_stb <= 1'b0;
      upd_ch <= '0;
    end else begin
      rd_value <= result[rd_ch];
      upd_stb <= wr && full;
      if (wr) begin
        acc[wr_ch] <= full ? '0 : sum;
        cnt[wr_ch] <= full ? '0 : cnt[wr_ch] + 1'b1;
        if (full) begin
          result[wr_ch] <= avg[SAMPLE_W-1:0];
          upd_ch <= wr_ch;
        end
      end
    end
  end
endmodule

// File: rtl/adc_scan.sv
// adc_scan: round-robin ADC request sequencer with tag-matched responses and averaging
module adc_scan
  import adc_scan_pkg::*;
#(
  parameter logic [7:0] CH_MASK = 8'hFF,
  parameter int PERIOD = 1000,
  parameter int AVG_SHIFT = 2,
  parameter int TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [23:0] adc_in_data,
  output logic        adc_in_wr,
  input  logic [23:0] adc_out_data,
  input  logic        adc_out_wr,
  input  logic [2:0]  rd_ch,
  output logic [9:0]  rd_value,
  output logic        upd_stb,
  output logic [2:0]  upd_ch,
  output logic        to_err
);
  localparam int TICK_W = $clog2(PERIOD);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  state_t state, state_n, after;
  logic [TICK_W-1:0] tick;
  logic [TO_W-1:0] to_cnt;
  logic [TAG_W-1:0] tag;
  logic [2:0] ch;
  logic [7:0] req;
  logic [SAMPLE_W-1:0] sample;
  logic match, tmo;
  logic [ADDR_LSB-SAMPLE_W-1:0] unused_rsv;
  assign unused_rsv = adc_out_data[ADDR_LSB-1:SAMPLE_W];
  assign match = state == WAIT_RSP && adc_out_wr && adc_out_data[ADDR_LSB +: 8] == req;
  assign tmo = state == WAIT_RSP && !match && to_cnt == TO_W'(TIMEOUT - 1);
  assign adc_in_wr = state == ISSUE;
  assign adc_in_data = adc_in_wr ? {16'b0, tag, ch} : '0;
  // The tick counter keeps running through the transaction, so an expired tick issues at once.
  assign after = !enable ? IDLE : tick == '0 ? ISSUE : WAIT_TICK;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = enable && CH_MASK != 8'h00 ? WAIT_TICK : IDLE;
      WAIT_TICK: state_n = !enable ? IDLE : tick == '0 ? ISSUE : WAIT_TICK;
      ISSUE:     state_n = WAIT_RSP;
      WAIT_RSP:  state_n = match ? STORE : tmo ? after : WAIT_RSP;
      STORE:     state_n = after;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tick <= '0;
      to_cnt <= '0;
      tag <= '0;
      ch <= first_ch(CH_MASK);
      req <= '0;
      sample <= '0;
      to_err <= 1'b0;
    end else begin
      state <= state_n;
      tick <= state == IDLE || state == ISSUE ? TICK_W'(PERIOD - 1) : tick != '0 ? tick - 1'b1 : tick;
      to_cnt <= state == WAIT_RSP ? to_cnt + 1'b1 : '0;
      if (state == ISSUE) begin
        tag <= tag + 1'b1;
        req <= {tag, ch};
      end
      if (match) sample <= adc_out_data[SAMPLE_W-1:0];
      if (state == STORE || tmo) ch <= next_ch(CH_MASK, ch);
      if (tmo) to_err <= 1'b1;
    end
  end
  adc_avg_bank #(.AVG_SHIFT(AVG_SHIFT)) u_bank (
    .clk(clk),
    .rst(rst),
    .wr(state == STORE),
    .wr_ch(ch),
    .wr_sample(sample),
    .rd_ch(rd_ch),
    .rd_value(rd_value),
    .upd_stb(upd_stb),
    .upd_ch(upd_ch)
  );
endmodule
